dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit data RAM words (power of two, at most 1024).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (at least 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: the rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port a, input, 32 bits: byte address from the core memory stage.
REQ-007 SHALL have port we, input, 1 bit: write enable from the core memory stage.
REQ-008 SHALL have port wd, input, 32 bits: write data.
REQ-009 SHALL have port rd, output, 32 bits: read data.
REQ-010 SHALL have port leds, output, 8 bits: the LED register.
REQ-011 SHALL have port uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL be the responder for the core data-memory initiator, with no handshake: every cycle is a potential access.
REQ-013 SHALL produce rd combinationally from a in the same cycle (asynchronous read), so the core captures it at the next edge.
REQ-014 SHALL perform all writes on the rising clk edge when we=1.
REQ-015 SHALL ignore a[1:0]: word access only, no byte enables.
REQ-016 SHALL map the RAM at 0x0000_0000 through 4*RAM_WORDS-1, indexed by a[log2(RAM_WORDS)+1:2]; RAM is read/write.
REQ-017 SHALL map LED at 0x8000_0000: read/write; a write stores wd[7:0]; a read returns {24'b0, leds}.
REQ-018 SHALL map CYCLE at 0x8000_0004: read-only; free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0; a read returns the pre-increment value for that cycle.
REQ-019 SHALL map TXDATA at 0x8000_0008: write-only (reads return 0); a write while idle starts transmission of wd[7:0].
REQ-020 SHALL map STATUS at 0x8000_000C: bit0 = busy, bit1 = overflow (sticky), other bits 0; writing 1 to bit1 clears overflow.
REQ-021 SHALL return 0 on reads of unmapped addresses and SHALL ignore writes to them.
REQ-022 SHALL implement a UART TX FSM with states IDLE, START, DATA, STOP.
REQ-023 In IDLE, on a TXDATA write, SHALL latch the byte and go to START at that edge; uart_tx=0 from the next cycle.
REQ-024 SHALL hold each state/bit for exactly CLKS_PER_BIT cycles using a baud counter.
REQ-025 In DATA, SHALL send 8 bits LSB first, then STOP (uart_tx=1), then return to IDLE.
REQ-026 SHALL keep a frame at exactly 10*CLKS_PER_BIT cycles.
REQ-027 SHALL assert busy whenever state is not IDLE.
REQ-028 SHALL drop a TXDATA write while busy, set overflow, and leave the frame in progress unaffected.
REQ-029 If a TXDATA write arrives in the same cycle as the STOP->IDLE transition, SHALL treat it as busy: the write is dropped and overflow is set.
REQ-030 If an overflow set and a clear occur in the same cycle, set SHALL win.

Reset
REQ-031 On rst_n=0, asynchronously: leds=0, CYCLE=0, FSM=IDLE, baud and bit counters=0, overflow=0, uart_tx=1.
REQ-032 Reset mid-frame SHALL abort the frame immediately, with uart_tx=1.
REQ-033 RAM contents SHALL NOT be reset.

Configuration
REQ-034 Macro DMEM_MMIO_UART_EN, when defined, SHALL compile in the UART FSM and the TXDATA/STATUS behaviour above.
REQ-035 When DMEM_MMIO_UART_EN is undefined: no UART logic; uart_tx tied to 1; TXDATA and STATUS read 0; writes to them ignored.

Verification
REQ-036 RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF; read 0x0000_0014 -> unchanged prior value.
REQ-037 LED/unmapped: write 0x1234_56A5 to 0x8000_0000 -> leds=0xA5, read=0x0000_00A5; write 0xFFFF_FFFF to 0x4000_0000 -> read 0, no other state changes.
REQ-038 CYCLE: release reset, read 0x8000_0004 on the 5th cycle -> 4; force a near-wrap (0xFFFF_FFFF) -> next cycle reads 0.
REQ-039 UART (CLKS_PER_BIT=4, macro defined): write 0x55 to TXDATA -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; STATUS=0x1 for 40 cycles, then 0x0.
REQ-040 Overflow: second TXDATA write 0xAA during the 0x55 frame -> frame unchanged, STATUS=0x3; write 0x2 to STATUS -> STATUS=0x1.
REQ-041 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> uart_tx=1 and STATUS=0 immediately; leds=0; RAM word at 0x10 retains 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data RAM plus LED, cycle counter and UART TX registers on the core data port.
// UART logic is compiled in only when DMEM_MMIO_UART_EN is defined.
module dmem_mmio #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_q;
  logic [31:0]   status_rd;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          io_hit;
  logic          led_sel;
  logic          cyc_sel;
  logic          tx_sel;
  logic          st_sel;

  assign ram_idx = a[AW+1:2];
  assign ram_hit = (a[31:AW+2] == '0);
  assign io_hit  = (a[31:4] == 28'h800_0000);
  assign led_sel = io_hit && (a[3:2] == 2'd0);
  assign cyc_sel = io_hit && (a[3:2] == 2'd1);
  assign tx_sel  = io_hit && (a[3:2] == 2'd2);
  assign st_sel  = io_hit && (a[3:2] == 2'd3);

  always_ff @(posedge clk) begin
    if (we && ram_hit)
      ram[ram_idx] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds    <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (we && led_sel)
        leds <= wd[7:0];
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      ram_hit: rd = ram[ram_idx];
      led_sel: rd = {24'b0, leds};
      cyc_sel: rd = cycle_q;
      st_sel:  rd = status_rd;
      default: rd = '0;
    endcase
  end

`ifdef DMEM_MMIO_UART_EN
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          ovf_q;
  logic          busy;
  logic          tx_wr;
  logic          baud_end;
  logic          tx_d;
  logic          unused_ok;

  assign busy      = (state_q != IDLE);
  assign tx_wr     = we && tx_sel;
  assign baud_end  = (baud_q == BAUD_MAX);
  assign status_rd = {30'b0, ovf_q, busy};
  assign uart_tx   = tx_d;
  assign unused_ok = ^a[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      // a dropped write in this cycle outranks a clear
      if (tx_wr && busy)
        ovf_q <= 1'b1;
      else if (we && st_sel && wd[1])
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tx_wr) begin
          state_d = START;
          byte_d  = wd[7:0];
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = byte_q[bit_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7)
            state_d = STOP;
          else
            bit_d = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic unused_ok;

  assign uart_tx   = 1'b1;
  assign status_rd = '0;
  assign unused_ok = ^{a[1:0], tx_sel};
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio against a cycle-level behavioural model.
// Works with or without DMEM_MMIO_UART_EN defined.
module tb_dmem_mmio;

  localparam int CPB = 4;
  localparam int RW  = 1024;
`ifdef DMEM_MMIO_UART_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  localparam logic [31:0] LED = 32'h8000_0000;
  localparam logic [31:0] CYC = 32'h8000_0004;
  localparam logic [31:0] TXD = 32'h8000_0008;
  localparam logic [31:0] STA = 32'h8000_000C;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  leds;
  logic        uart_tx;

  dmem_mmio #(
    .RAM_WORDS(RW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .we(we),
    .wd(wd),
    .rd(rd),
    .leds(leds),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_ram [int];
  logic [7:0]  m_leds;
  logic [31:0] m_cyc;
  bit          m_act;
  int          m_t;
  logic [7:0]  m_byte;
  bit          m_ovf;

  int errs;
  int checks;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] ad);
    int idx;
    idx = int'(ad[11:2]);
    if (ad < 32'(4 * RW))
      return m_ram.exists(idx) ? m_ram[idx] : 32'hxxxx_xxxx;
    if (ad[31:2] == LED[31:2]) return {24'b0, m_leds};
    if (ad[31:2] == CYC[31:2]) return m_cyc;
    if (ad[31:2] == STA[31:2])
      return UEN ? {30'b0, m_ovf, m_act} : 32'h0;
    return 32'h0;
  endfunction

  // line level as a function of time since the frame started
  function automatic logic m_tx();
    int k;
    if (!UEN || !m_act) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_leds = '0;
    m_cyc  = '0;
    m_act  = 1'b0;
    m_t    = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic step(input logic [31:0] ad, input logic w,
                      input logic [31:0] d, input string tag);
    logic [31:0] exp;
    bit prev;
    @(negedge clk);
    a  = ad;
    we = w;
    wd = d;
    #1;
    exp = m_read(ad);
    if (!$isunknown(exp)) chk({tag, ":rd"}, rd, exp);
    chk({tag, ":tx"}, {31'b0, uart_tx}, {31'b0, m_tx()});
    chk({tag, ":leds"}, {24'b0, leds}, {24'b0, m_leds});
    @(posedge clk);
    prev = m_act;
    if (prev) begin
      m_t++;
      if (m_t == 10 * CPB) m_act = 1'b0;
    end
    if (w) begin
      if (ad < 32'(4 * RW)) m_ram[int'(ad[11:2])] = d;
      else if (ad[31:2] == LED[31:2]) m_leds = d[7:0];
      else if (UEN && ad[31:2] == STA[31:2] && d[1]) m_ovf = 1'b0;
      if (UEN && ad[31:2] == TXD[31:2]) begin
        if (prev) m_ovf = 1'b1;
        else begin
          m_act  = 1'b1;
          m_t    = 0;
          m_byte = d[7:0];
        end
      end
    end
    m_cyc++;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ad;
    int op;
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    a      = CYC;
    we     = 1'b0;
    wd     = '0;
    m_byte = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cycle", rd, 32'h0);
    chk("rst_leds", {24'b0, leds}, 32'h0);
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    release_reset();

    for (int i = 0; i < 5; i++) step(CYC, 1'b0, '0, "cycle");

    step(32'h14, 1'b1, 32'h0BAD_F00D, "ram_pre");
    step(32'h10, 1'b1, 32'hDEAD_BEEF, "ram_wr");
    step(32'h10, 1'b0, '0, "ram_rd10");
    step(32'h13, 1'b0, '0, "ram_rd13");
    step(32'h14, 1'b0, '0, "ram_rd14");
    chk("ram14_direct", rd, 32'h0BAD_F00D);

    step(LED, 1'b1, 32'h1234_56A5, "led_wr");
    step(LED, 1'b0, '0, "led_rd");
    chk("led_direct", rd, 32'h0000_00A5);
    step(32'h4000_0000, 1'b1, 32'hFFFF_FFFF, "unm_wr");
    step(32'h4000_0000, 1'b0, '0, "unm_rd");
    step(TXD, 1'b0, '0, "txd_rd");

    #1;
    dut.cycle_q = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    step(CYC, 1'b0, '0, "wrap_hi");
    step(CYC, 1'b0, '0, "wrap_lo");

    step(TXD, 1'b1, 32'h55, "tx55");
    for (int i = 0; i < 44; i++) step(STA, 1'b0, '0, "frame55");

    step(TXD, 1'b1, 32'h55, "ovf_a");
    for (int i = 0; i < 6; i++) step(STA, 1'b0, '0, "ovf_pre");
    step(TXD, 1'b1, 32'hAA, "ovf_b");
    for (int i = 0; i < 4; i++) step(STA, 1'b0, '0, "ovf_set");
    step(STA, 1'b1, 32'h2, "ovf_clr");
    step(STA, 1'b0, '0, "ovf_after");
    for (int i = 0; i < 35; i++) step(STA, 1'b0, '0, "ovf_drain");

    step(TXD, 1'b1, 32'hC3, "edge_a");
    for (int i = 0; i < 39; i++) step(STA, 1'b0, '0, "edge_run");
    step(TXD, 1'b1, 32'h77, "edge_b");
    step(STA, 1'b0, '0, "edge_sta");
    step(STA, 1'b1, 32'h2, "edge_clr");
    step(STA, 1'b0, '0, "edge_sta2");

    for (int i = 0; i < 800; i++) begin
      op = int'($urandom_range(0, 99));
      ad = {20'b0, 4'b0, 6'($urandom_range(16, 63)), 2'($urandom)};
      if (op < 30) step(ad, 1'b1, $urandom, "r_ramw");
      else if (op < 50) step(ad, 1'b0, '0, "r_ramr");
      else if (op < 57) step(LED, 1'b1, $urandom, "r_ledw");
      else if (op < 62) step(LED, 1'b0, '0, "r_ledr");
      else if (op < 68) step(CYC, $urandom_range(0, 1) == 1, $urandom, "r_cyc");
      else if (op < 73) step(TXD, 1'b1, $urandom, "r_txw");
      else if (op < 82) step(STA, 1'b0, '0, "r_star");
      else if (op < 86) step(STA, 1'b1, $urandom, "r_staw");
      else
        step({2'b01, 30'($urandom)}, $urandom_range(0, 1) == 1, $urandom,
             "r_unm");
    end

    for (int i = 0; i < 45; i++) step(STA, 1'b0, '0, "drain");
    step(LED, 1'b1, 32'h3C, "mid_led");
    step(TXD, 1'b1, 32'h96, "mid_tx");
    for (int i = 0; i < 60; i++) begin
      if (m_act && m_t == 4 * CPB + 1) break;
      step(STA, 1'b0, '0, "mid_run");
    end
    @(negedge clk);
    a  = STA;
    we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("mid_rst_sta", rd, 32'h0);
    chk("mid_rst_leds", {24'b0, leds}, 32'h0);
    m_reset();
    release_reset();
    step(32'h10, 1'b0, '0, "mid_ram");
    chk("mid_ram_direct", rd, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(STA, 1'b0, '0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
